// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
// Receiver states and default oversampling/baud values.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE   = 16;
  localparam int UART_DEFAULT_BAUD = 115200;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: fractional accumulator producing oversample ticks.
// Adds baud*OVERSAMPLE per clock, ticks on each CLK_FREQ crossing.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        clear,
  input  logic [31:0] baud,
  output logic        tick
);

  localparam logic [39:0] FREQ = 40'(CLK_FREQ);
  localparam logic [39:0] OVS  = 40'(OVERSAMPLE);

  logic [39:0] acc;
  logic [39:0] step;
  logic [39:0] sum;

  assign step = {8'd0, baud} * OVS;
  assign sum  = acc + step;

  // Accumulate; on crossing, wrap and tick. Oversized steps pin
  // the accumulator at zero so it never grows without bound.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= FREQ) begin
      acc  <= (step > FREQ) ? '0 : sum - FREQ;
      tick <= 1'b1;
    end else begin
      acc  <= sum;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled serial receiver, 8N1 by default.
// Emits rx_data/rx_done on good frames, frame_error on bad stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [31:0]           baud_rate,
  input  logic                  UART_RX,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_done,
  output logic                  frame_error,
  output logic                  rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  uart_rx_state_t state, state_n;

  logic [1:0]            sync_q;
  logic                  rxs;
  logic                  rxs_d;
  logic [31:0]           baud_q;
  logic                  tick;
  logic                  acc_clr;
  logic                  start_edge;

  logic [SW-1:0]         scnt, scnt_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [DATA_WIDTH:0]   shcat;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  done_n;
  logic                  ferr_n;
  logic                  busy_n;

  assign rxs   = sync_q[1];
  assign shcat = {rxs, shreg};

  assign start_edge = (state == IDLE) && rxs_d && !rxs
                      && (baud_rate != 32'd0);

  // Two-flop synchronizer plus one delayed copy for edge detect.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync_q <= 2'b11;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], UART_RX};
      rxs_d  <= rxs;
    end
  end

  // Baud value tracks the register only between frames.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      baud_q <= 32'(UART_DEFAULT_BAUD);
    end else if (state == IDLE) begin
      baud_q <= baud_rate;
    end
  end

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .clear         (acc_clr),
    .baud          (baud_q),
    .tick          (tick)
  );

  // FSM and datapath registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state       <= IDLE;
      scnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_n;
      scnt        <= scnt_n;
      bcnt        <= bcnt_n;
      shreg       <= shreg_n;
      rx_data     <= data_n;
      rx_done     <= done_n;
      frame_error <= ferr_n;
      rx_busy     <= busy_n;
    end
  end

  // Next-state logic: start qualify, data shift, stop check.
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    data_n  = rx_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    busy_n  = rx_busy;
    acc_clr = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_edge) begin
          acc_clr = 1'b1;
          scnt_n  = '0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end

      START: begin
        if (tick) begin
          if (scnt == S_MID) begin
            if (rxs) begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end else begin
              scnt_n  = '0;
              bcnt_n  = '0;
              state_n = DATA;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_n  = '0;
            shreg_n = shcat[DATA_WIDTH:1];
            bcnt_n  = bcnt + 1'b1;
            if (bcnt == B_LAST) begin
              bcnt_n  = '0;
              state_n = STOP;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            if (rxs) begin
              data_n = shreg;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
            scnt_n  = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
